// File: rtl/cnt_seq_pkg.sv
// Shared types and helpers for the mod-N sequencing controller.
// Holds the FSM state encoding, default widths and config checking.
package cnt_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned WRAP_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    function automatic logic cfg_legal(
        input int unsigned m,
        input int unsigned i,
        input int unsigned w,
        input int unsigned max_m
    );
        return (m >= 2) && (m <= max_m) && (i < m) && (w >= 1);
    endfunction

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Job request handshake between a host and the mod-N sequencer.
// The host drives valid and the job fields; the sequencer returns ready.
interface cnt_seq_ctrl_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WRAP_W = 8
);

    logic              valid;
    logic              ready;
    logic [WIDTH:0]    mod;
    logic [WIDTH-1:0]  init;
    logic [WRAP_W-1:0] wraps;

    modport master (
        output valid,
        output mod,
        output init,
        output wraps,
        input  ready
    );

    modport slave (
        input  valid,
        input  mod,
        input  init,
        input  wraps,
        output ready
    );

endinterface

// File: rtl/cnt_seq_ctrl_mod_counter.sv
// Presettable modulo-N counter; mod is WIDTH+1 bits so N=2**WIDTH fits.
// wrap_now flags the step that takes count from N-1 back to 0.
module mod_counter
    import cnt_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] init,
    input  logic [WIDTH:0]   mod,
    output logic [WIDTH-1:0] count,
    output logic             wrap_now
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   last;

    assign last     = mod - (WIDTH+1)'(1);
    assign wrap_now = en && ({1'b0, count_q} == last);
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = init;
        end else if (en) begin
            count_d = wrap_now ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Accepts a mod/init/wraps job, runs the mod-N counter for that many
// wraps and pulses done; stop aborts without done or wrap.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned WRAP_W = WRAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    cnt_seq_ctrl_if.slave    cfg,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned MAX_MOD = 2**WIDTH;

    state_e            state_q, state_d;
    logic [WIDTH:0]    mod_q, mod_d;
    logic [WIDTH-1:0]  init_q, init_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [WRAP_W-1:0] wcnt_q, wcnt_d;
    logic [WRAP_W-1:0] wcnt_inc;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              legal;
    logic              cnt_load;
    logic              cnt_en;
    logic              wrap_now;

    assign legal = cfg_legal(32'(cfg.mod), 32'(cfg.init),
                             32'(cfg.wraps), MAX_MOD);

    assign cfg.ready = (state_q == IDLE);
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wcnt_inc  = wcnt_q + WRAP_W'(1);

    // stop gates the counter so an aborted job freezes where it was
    assign cnt_load = (state_q == LOAD) && !stop;
    assign cnt_en   = (state_q == RUN) && !stop;

    mod_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .en      (cnt_en),
        .init    (init_q),
        .mod     (mod_q),
        .count   (count),
        .wrap_now(wrap_now)
    );

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        init_d  = init_q;
        wraps_d = wraps_q;
        wcnt_d  = wcnt_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg.valid) begin
                    if (legal) begin
                        mod_d   = cfg.mod;
                        init_d  = cfg.init;
                        wraps_d = cfg.wraps;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (wrap_now) begin
                    wrap_d = 1'b1;
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == wraps_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mod_q   <= '0;
            init_q  <= '0;
            wraps_q <= '0;
            wcnt_q  <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            init_q  <= init_d;
            wraps_q <= wraps_d;
            wcnt_q  <= wcnt_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: vector table plus hand-built
// sequences for long jobs, stop, and reset mid-job.
module tb_cnt_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       stop;
    logic [3:0] count;
    logic       wrap;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk;
    int n_fail;

    cnt_seq_ctrl_if #(.WIDTH(4), .WRAP_W(8)) cfg_if ();

    cnt_seq_ctrl #(
        .WIDTH (4),
        .WRAP_W(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cfg  (cfg_if),
        .stop (stop),
        .count(count),
        .wrap (wrap),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] m;
        logic [3:0] i;
        logic [7:0] w;
        logic [3:0] c;
        logic       wr;
        logic       dn;
        logic       er;
        logic       bz;
        logic       rd;
    } vec_t;

    vec_t tbl [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // packed view of all outputs: count,wrap,done,err,busy,ready
    function automatic logic [31:0] outs();
        return {23'd0, count, wrap, done, err, busy, cfg_if.ready};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] c,
        input logic wr, input logic dn, input logic er,
        input logic bz, input logic rd);
        return {23'd0, c, wr, dn, er, bz, rd};
    endfunction

    task automatic drive(input logic v, input logic [4:0] m,
                         input logic [3:0] i, input logic [7:0] w);
        cfg_if.valid = v;
        cfg_if.mod   = m;
        cfg_if.init  = i;
        cfg_if.wraps = w;
    endtask

    // Expected values follow the job definition: count=init one edge
    // after accept, then mod-N steps; done on the last wrap.
    task automatic run_job(input string tag, input int m, input int i,
                           input int w);
        int total;
        int exp_c;
        int nwrap;
        int last_wrap;
        logic ew;
        logic ed;
        total     = 1 + (m - i) + m * (w - 1);
        exp_c     = 0;
        nwrap     = 0;
        last_wrap = -1;
        drive(1'b1, 5'(m), 4'(i), 8'(w));
        tick();
        drive(1'b0, 5'd0, 4'd0, 8'd0);
        chk({tag, "_accept"}, {30'd0, busy, cfg_if.ready}, 32'b10);
        for (int n = 1; n <= total; n++) begin
            tick();
            ew = 1'b0;
            if (n == 1) begin
                exp_c = i;
            end else if (exp_c == m - 1) begin
                exp_c = 0;
                ew    = 1'b1;
            end else begin
                exp_c = exp_c + 1;
            end
            ed = (n == total);
            if (wrap) begin
                if (last_wrap >= 0 && n - last_wrap != m)
                    chk({tag, "_wrap_gap"}, 32'(n - last_wrap), 32'(m));
                last_wrap = n;
                nwrap++;
            end
            chk($sformatf("%s_step%0d", tag, n), outs(),
                pack(4'(exp_c), ew, ed, 1'b0, !ed, 1'b0));
        end
        chk({tag, "_nwrap"}, 32'(nwrap), 32'(w));
        tick();
        chk({tag, "_idle"}, outs(),
            pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        stop   = 1'b0;
        drive(1'b0, 5'd0, 4'd0, 8'd0);

        tbl[0]  = '{1'b1, 5'd7, 4'd0, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 5'd1, 4'd0, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 5'd7, 4'd7, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 5'd7, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 5'd17, 4'd0, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        tick();
        tick();
        chk("reset", outs(), pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b0;

        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].v, tbl[k].m, tbl[k].i, tbl[k].w);
            tick();
            chk($sformatf("vec%0d", k), outs(),
                pack(tbl[k].c, tbl[k].wr, tbl[k].dn, tbl[k].er,
                     tbl[k].bz, tbl[k].rd));
        end
        drive(1'b0, 5'd0, 4'd0, 8'd0);
        tick();

        run_job("m15", 15, 12, 2);
        run_job("m16", 16, 15, 3);

        // stop coinciding with count==mod-1; cfg_valid while busy
        drive(1'b1, 5'd5, 4'd2, 8'd3);
        tick();
        drive(1'b0, 5'd0, 4'd0, 8'd0);
        tick();
        chk("stop_c2", 32'(count), 32'd2);
        drive(1'b1, 5'd1, 4'd0, 8'd0);
        tick();
        chk("busy_cfg", outs(), pack(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b0, 5'd0, 4'd0, 8'd0);
        tick();
        chk("stop_c4", 32'(count), 32'd4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_edge", outs(), pack(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        chk("stop_after", outs(), pack(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        // reset mid-run, then an immediate new job
        drive(1'b1, 5'd7, 4'd0, 8'd2);
        tick();
        drive(1'b0, 5'd0, 4'd0, 8'd0);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst", 32'(count), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst", outs(), pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b0;
        run_job("m3", 3, 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
